instr_fetch_unit: RTL

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

---
 rtl/riscv_pkg.sv | 22 ++
 rtl/fetch_fifo.sv | 64 ++++++
 rtl/instr_fetch_unit.sv | 95 +++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared fetch/decode types: instruction and PC widths, reset PC, fetch entry record.
package riscv_pkg;

  localparam int XLEN_INSTR = 32;
  localparam int PC_W       = 32;

  localparam logic [PC_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // One prefetched instruction together with the byte address it came from.
  typedef struct packed {
    logic [PC_W-1:0]       pc;
    logic [XLEN_INSTR-1:0] instr;
  } fetch_entry_t;

  localparam int FETCH_ENTRY_W = PC_W + XLEN_INSTR;

  // Instruction addresses are always word aligned; low two bits are dropped.
  function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] addr);
    return {addr[PC_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO holding prefetched instructions. The head entry is
// read straight from registered storage so the consumer never sees a
// combinational path from the write port.
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] pop_data_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok;
  logic             pop_ok;

  assign push_ok = push_i && (count_q != CW'(DEPTH));
  assign pop_ok  = pop_i && (count_q != '0);

  // Pointer and occupancy next-state; DEPTH is a power of two so pointers wrap naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (push_ok && !pop_ok)      count_d = count_q + CW'(1);
    else if (pop_ok && !push_ok) count_d = count_q - CW'(1);
  end

  // Control state; a clear empties the queue exactly like reset.
  always_ff @(posedge clock) begin
    if (reset || clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents need no reset because count gates visibility.
  always_ff @(posedge clock) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign pop_data_o = mem_q[rd_ptr_q];
  assign empty_o    = (count_q == '0);
  assign count_o    = count_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: issues sequential word fetches, tracks the
// single in-flight request, squashes it on redirect and buffers responses in
// a prefetch queue feeding decode.
module instr_fetch_unit
  import riscv_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic          clock,
  input  logic          reset,
  output logic          imem_req,
  output logic [31:0]   imem_addr,
  input  logic [31:0]   imem_rdata,
  input  logic          redirect_valid,
  input  logic [31:0]   redirect_pc,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_instr,
  output logic [31:0]   out_pc,
  output logic [CW-1:0] fifo_count
);

  logic [PC_W-1:0] pc_q, pc_d;
  logic            inflight_q, inflight_d;
  logic [PC_W-1:0] inflight_pc_q, inflight_pc_d;

  logic [CW-1:0]   count_raw;
  logic            fifo_empty;
  logic [CW:0]     occupancy;
  logic            pop;
  fetch_entry_t    push_entry;
  fetch_entry_t    head_entry;
  logic [FETCH_ENTRY_W-1:0] head_bits;

  // Slots already claimed: stored entries plus the response still on its way.
  // A pop this cycle deliberately does not free a slot for this cycle's request.
  assign occupancy = {1'b0, count_raw} + (CW+1)'(inflight_q);
  assign imem_req  = !reset && !redirect_valid && (occupancy < (CW+1)'(DEPTH));
  assign imem_addr = pc_q;

  assign out_valid  = !reset && !fifo_empty;
  assign pop        = out_valid && out_ready;
  assign head_entry = fetch_entry_t'(head_bits);
  assign out_instr  = out_valid ? head_entry.instr : '0;
  assign out_pc     = out_valid ? head_entry.pc    : '0;
  assign fifo_count = reset ? '0 : count_raw;

  assign push_entry.pc    = inflight_pc_q;
  assign push_entry.instr = imem_rdata;

  // Next-fetch PC and in-flight tracking; a redirect blocks this cycle's
  // request, so nothing issued before it can land after the flush.
  always_comb begin
    pc_d          = pc_q;
    inflight_d    = imem_req;
    inflight_pc_d = inflight_pc_q;
    if (redirect_valid) begin
      pc_d = align_pc(redirect_pc);
    end else if (imem_req) begin
      pc_d          = pc_q + 32'd4;
      inflight_pc_d = pc_q;
    end
  end

  // Fetch state registers; reset drops any outstanding response.
  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q          <= align_pc(RESET_PC);
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (FETCH_ENTRY_W)
  ) u_fifo (
    .clock       (clock),
    .reset       (reset),
    .clear_i     (redirect_valid),
    .push_i      (inflight_q),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .pop_data_o  (head_bits),
    .empty_o     (fifo_empty),
    .count_o     (count_raw)
  );

endmodule
